// File: rtl/soc_system_clkdiv_mgr.sv
// Multi-channel reprogrammable clock divider with rising-edge enables and a lock indicator.
// Ratio updates go through a single pending slot and land on the target channel's period boundary.
module soc_system_clkdiv_mgr #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            outclk_q, outclk_d;
  logic [NUM_CH-1:0]            outclk_en_q, outclk_en_d;
  logic [NUM_CH-1:0]            at_end_c;
  logic                         pend_q, pend_d;
  logic [CH_W-1:0]              pch_q, pch_d;
  logic [DIV_W-1:0]             pdiv_q, pdiv_d;
  logic                         cfg_ready_q, cfg_ready_d;
  logic                         cfg_err_q, cfg_err_d;
  logic [LOCK_W-1:0]            lock_cnt_q, lock_cnt_d;
  logic                         locked_q, locked_d;
  logic                         xfer_c, bad_c, accept_c, apply_c;

  // Handshake decode and pending-slot bookkeeping
  always_comb begin
    xfer_c   = cfg_valid && cfg_ready_q;
    bad_c    = (cfg_div < DIV_W'(2)) || (32'(cfg_ch) >= NUM_CH);
    accept_c = xfer_c && !bad_c;
    apply_c  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      at_end_c[i] = (cnt_q[i] == div_q[i] - DIV_W'(1));
      if (pend_q && (pch_q == CH_W'(i)) && at_end_c[i]) apply_c = 1'b1;
    end

    pend_d = pend_q;
    pch_d  = pch_q;
    pdiv_d = pdiv_q;
    if (apply_c) pend_d = 1'b0;
    if (accept_c) begin
      pend_d = 1'b1;
      pch_d  = cfg_ch;
      pdiv_d = cfg_div;
    end
    cfg_ready_d = !pend_d;
    cfg_err_d   = xfer_c && bad_c;

    lock_cnt_d = lock_cnt_q;
    if (accept_c) begin
      lock_cnt_d = '0;
    end else if (!pend_q && (lock_cnt_q < LOCK_W'(LOCK_CYCLES))) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
    locked_d = (lock_cnt_d == LOCK_W'(LOCK_CYCLES));
  end

  // Per-channel counters; high phase is cnt < ceil(div/2), i.e. 2*cnt < div
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      outclk_d[i]    = ({cnt_q[i], 1'b0} < {1'b0, div_q[i]});
      outclk_en_d[i] = (cnt_q[i] == '0);
      cnt_d[i]       = at_end_c[i] ? '0 : cnt_q[i] + DIV_W'(1);
      div_d[i]       = (apply_c && (pch_q == CH_W'(i))) ? pdiv_q : div_q[i];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DEFAULT_DIV);
        cnt_q[i] <= '0;
      end
      outclk_q    <= '0;
      outclk_en_q <= '0;
      pend_q      <= 1'b0;
      pch_q       <= '0;
      pdiv_q      <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_en_d;
      pend_q      <= pend_d;
      pch_q       <= pch_d;
      pdiv_q      <= pdiv_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;
  assign locked    = locked_q;

endmodule
